vend_sequencer: RTL
===================

Name: vend_sequencer

Overview:
- Multi-item vending controller that accumulates coin credit and checks each selection against per-item prices and stock flags.
- Sequences the product dispenser and the change hopper through req/ack handshakes.
- Sits between the coin acceptor front end and the dispenser/hopper actuators.
- Prices are loaded by the config block; all credit arithmetic is in 5-rs units.

Parameters:
- NUM_ITEMS, 4, number of selectable items (min 2).
- CREDIT_W, 6, width of the credit and price fields, in 5-rs units.
- MAX_CREDIT, 20, maximum credit held, in units (100 rs).
- TIMEOUT_CYCLES, 1000, idle cycles in ACCUM before auto-refund (used only with VEND_TIMEOUT_EN).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- coin  in  2  one-cycle coin code: 01 = 5 rs, 10 = 10 rs, 00 = none, 11 = invalid.
- sel_valid  in  1  one-cycle selection strobe.
- sel_item  in  $clog2(NUM_ITEMS)  selected item index.
- cancel  in  1  one-cycle refund request.
- prices  in  NUM_ITEMS*CREDIT_W  packed per-item prices; item i is at bits [i*CREDIT_W +: CREDIT_W].
- item_empty  in  NUM_ITEMS  per-item out-of-stock flags.
- disp_req  out  1  dispense request, level.
- disp_item  out  $clog2(NUM_ITEMS)  item to dispense; valid while disp_req is high.
- disp_ack  in  1  dispenser done, one-cycle pulse.
- chg_req  out  1  request for one 5-rs change coin, level.
- chg_ack  in  1  one change coin ejected, one-cycle pulse.
- credit  out  CREDIT_W  current credit in units.
- busy  out  1  high in VEND or CHANGE.
- coin_reject  out  1  one-cycle pulse: coin returned uncredited.
- sel_error  out  1  one-cycle pulse: selection refused.

Behaviour:
- Reset: state = IDLE and every output = 0 (credit, disp_req, disp_item, chg_req, busy, coin_reject, sel_error). Credit held at reset is discarded.
- All outputs are registered. Every response appears on the cycle after the triggering input.
- Input priority within one cycle: cancel > sel_valid > coin.
  - A coin arriving in the same cycle as an accepted cancel or a sel_valid (accepted or refused) is rejected: coin_reject pulses and credit is unchanged.
- Coin handling, in IDLE/ACCUM only:
  - 01 adds 1 unit; 10 adds 2 units.
  - Code 11 is rejected.
  - A coin that would make credit exceed MAX_CREDIT is rejected.
  - Any coin arriving in VEND or CHANGE is rejected.
- IDLE (credit = 0):
  - An accepted coin moves to ACCUM.
  - sel_valid pulses sel_error and the state holds.
  - cancel is ignored.
- ACCUM (credit > 0):
  - sel_valid is refused (sel_error pulses, state and credit hold) if item_empty[sel_item] = 1, or price = 0, or price > credit.
  - Otherwise: credit <= credit - price; disp_item <= sel_item; disp_req <= 1; state -> VEND.
  - Prices are sampled only on the sel_valid cycle.
  - cancel -> CHANGE (full refund).
- VEND:
  - disp_req holds high until disp_ack is sampled high.
  - On the cycle after the ack, disp_req = 0 and the state moves to CHANGE if credit > 0, otherwise to IDLE.
  - cancel and sel_valid are ignored.
- CHANGE:
  - chg_req = 1 while credit > 0.
  - Each sampled chg_ack decrements credit by 1.
  - The ack that brings credit to 0 drops chg_req on the next cycle and returns to IDLE.
  - cancel and sel_valid are ignored.
- Stray acks: disp_ack outside VEND and chg_ack while chg_req = 0 are ignored.
- busy = 1 exactly when the state is VEND or CHANGE.
- Exactly one item is dispensed per accepted selection. Multi-vend on leftover credit is not supported; the remainder is always refunded.
- Credit never underflows; the price <= credit check precedes any subtraction.

Optional Feature:
- VEND_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) runs in ACCUM.
  - It is cleared by every accepted coin, every refused selection and every ACCUM entry.
  - When it reaches TIMEOUT_CYCLES, the block enters CHANGE and refunds the full credit, exactly as for cancel.
  - The counter is held at 0 outside ACCUM.
- VEND_TIMEOUT_EN undefined: no counter is built, and ACCUM waits indefinitely.

Test Plan:
- Purchase with change. Setup: prices = {item3: 4, item2: 3, item1: 3, item0: 2}. Stimulus: coin 10, then coin 10 (credit = 4); sel_item = 1. Required: disp_req = 1 with disp_item = 1 and credit = 1; after disp_ack, one chg_req/chg_ack cycle; credit = 0, state IDLE.
- Refused selections:
  - credit 1 with item 0 (price 2) selected -> sel_error pulse, credit stays 1.
  - item_empty[2] = 1 with credit 4, item 2 selected -> sel_error pulse, no disp_req.
- Coin rejection:
  - credit = 19 plus coin 10 -> coin_reject, credit stays 19.
  - coin 11 -> coin_reject.
  - coin 01 during VEND -> coin_reject, credit unchanged.
- Cancel: credit 3 and cancel -> three chg_ack cycles decrement credit to 0, then IDLE. Cancel in the same cycle as coin 01 -> coin rejected, refund of 3.
- Reset mid-operation: rst during VEND with disp_req = 1 -> next cycle all outputs 0, state IDLE; a later disp_ack is ignored.
- Timeout (VEND_TIMEOUT_EN, TIMEOUT_CYCLES = 8): credit 2 and no activity -> chg_req asserts after 8 idle cycles. Without the macro -> no refund after 100 cycles.

Source files
------------

// File: rtl/vend_sequencer.sv
// vend_sequencer: coin credit, per-item price check, dispense/change handshakes.
// Define VEND_TIMEOUT_EN to add the ACCUM idle-timeout auto-refund.
module vend_sequencer #(
    parameter int NUM_ITEMS      = 4,
    parameter int CREDIT_W       = 6,
    parameter int MAX_CREDIT     = 20,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    coin,
    input  logic                          sel_valid,
    input  logic [$clog2(NUM_ITEMS)-1:0]  sel_item,
    input  logic                          cancel,
    input  logic [NUM_ITEMS*CREDIT_W-1:0] prices,
    input  logic [NUM_ITEMS-1:0]          item_empty,
    output logic                          disp_req,
    output logic [$clog2(NUM_ITEMS)-1:0]  disp_item,
    input  logic                          disp_ack,
    output logic                          chg_req,
    input  logic                          chg_ack,
    output logic [CREDIT_W-1:0]           credit,
    output logic                          busy,
    output logic                          coin_reject,
    output logic                          sel_error
);

    localparam int IW = $clog2(NUM_ITEMS);
    localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W+1)'(MAX_CREDIT);

    if (NUM_ITEMS < 2 || MAX_CREDIT >= (1 << CREDIT_W) ||
        TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("vend_sequencer: illegal parameter set");
    end

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        VEND,
        CHANGE
    } state_t;

    state_t state;

    logic [CREDIT_W-1:0] price;
    logic                empty;
    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   sum;
    logic                coin_in;
    logic                coin_ok;
    logic                sel_ok;
    logic                tmo_hit;

    // Out-of-range indices read as empty so they are always refused.
    always_comb begin
        price = '0;
        empty = 1'b1;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (sel_item == IW'(i)) begin
                price = prices[i*CREDIT_W +: CREDIT_W];
                empty = item_empty[i];
            end
        end
    end

    always_comb begin
        coin_val = '0;
        case (coin)
            2'b01:   coin_val = (CREDIT_W+1)'(1);
            2'b10:   coin_val = (CREDIT_W+1)'(2);
            default: coin_val = '0;
        endcase
    end

    assign coin_in = coin != 2'b00;
    assign sum     = {1'b0, credit} + coin_val;
    assign coin_ok = (coin == 2'b01 || coin == 2'b10) && sum <= MAX_C;
    assign sel_ok  = !empty && price != '0 && price <= credit;

`ifdef VEND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt;

    assign tmo_hit = state == ACCUM && tmo_cnt == TW'(TIMEOUT_CYCLES);

    // Any ACCUM activity, or leaving ACCUM, restarts the idle count.
    always_ff @(posedge clk) begin
        if (rst || state != ACCUM || cancel || sel_valid ||
            coin_ok || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            credit      <= '0;
            disp_req    <= 1'b0;
            disp_item   <= '0;
            chg_req     <= 1'b0;
            busy        <= 1'b0;
            coin_reject <= 1'b0;
            sel_error   <= 1'b0;
        end else begin
            coin_reject <= 1'b0;
            sel_error   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (sel_valid) begin
                        sel_error   <= 1'b1;
                        coin_reject <= coin_in;
                    end else if (coin_ok) begin
                        credit <= sum[CREDIT_W-1:0];
                        state  <= ACCUM;
                    end else begin
                        coin_reject <= coin_in;
                    end
                end
                ACCUM: begin
                    if (cancel || tmo_hit) begin
                        coin_reject <= coin_in;
                        chg_req     <= 1'b1;
                        busy        <= 1'b1;
                        state       <= CHANGE;
                    end else if (sel_valid) begin
                        coin_reject <= coin_in;
                        if (sel_ok) begin
                            credit    <= credit - price;
                            disp_item <= sel_item;
                            disp_req  <= 1'b1;
                            busy      <= 1'b1;
                            state     <= VEND;
                        end else begin
                            sel_error <= 1'b1;
                        end
                    end else if (coin_ok) begin
                        credit <= sum[CREDIT_W-1:0];
                    end else begin
                        coin_reject <= coin_in;
                    end
                end
                VEND: begin
                    coin_reject <= coin_in;
                    if (disp_ack) begin
                        disp_req  <= 1'b0;
                        disp_item <= '0;
                        if (credit != '0) begin
                            chg_req <= 1'b1;
                            state   <= CHANGE;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                CHANGE: begin
                    coin_reject <= coin_in;
                    if (chg_req && chg_ack) begin
                        credit <= credit - CREDIT_W'(1);
                        if (credit == CREDIT_W'(1)) begin
                            chg_req <= 1'b0;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
